// File: rtl/matrix_key_scan_if.sv
// Keypad-side bundle for matrix_key_scan: row strobe out, column sense in, key event reporting.
interface matrix_key_scan_if;
  logic [3:0] Col_In;
  logic [3:0] Row_Out;
  logic [3:0] Key_Code;
  logic       Key_Valid;
  logic       Key_Down;

  modport master (output Col_In, input Row_Out, Key_Code, Key_Valid, Key_Down);
  modport slave  (input Col_In, output Row_Out, Key_Code, Key_Valid, Key_Down);
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner: active-low row strobe, synchronized column read-back, whole-frame debounce
// and single-key event reporting. Auto-repeat is built only when KEY_REPEAT_EN is defined.
module matrix_key_scan #(
  parameter logic [18:0] SCAN_TICK     = 19'd500_000,
  parameter logic [3:0]  DEBOUNCE_CNT  = 4'd4
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [7:0]  REPEAT_FRAMES = 8'd50
`endif
) (
  input  logic             CLK,
  input  logic             RSTn,
  matrix_key_scan_if.slave bus
);
  // state     | meaning
  // ST_OPEN   | unlocked: the next debounced single key is reported
  // ST_LOCKED | a key or chord was taken; wait for a debounced all-released frame
  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [18:0] r_cnt;
  logic [1:0]  r_row;
  logic [3:0]  r_col_s1;
  logic [3:0]  r_col_s2;
  logic [15:0] r_raw;
  logic [15:0] r_stored;
  logic [15:0] r_deb;
  logic [3:0]  r_match;
  logic        r_frame_done;
  logic [3:0]  r_key_code;
  logic        r_key_valid;

  logic        w_tick;
  logic [3:0]  w_match_inc;
  logic        w_deb_upd;
  logic        w_fire;
  logic        w_rep_fire;
  logic [3:0]  w_key_idx;

  assign w_tick      = (r_cnt == SCAN_TICK);
  assign w_match_inc = r_match + 4'd1;
  // Saturated count never equals DEBOUNCE_CNT again after incrementing, so this fires once per new frame.
  assign w_deb_upd   = r_frame_done && (r_raw == r_stored) && (w_match_inc == DEBOUNCE_CNT);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt        <= '0;
      r_row        <= '0;
      r_col_s1     <= 4'hF;
      r_col_s2     <= 4'hF;
      r_raw        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_col_s1     <= bus.Col_In;
      r_col_s2     <= r_col_s1;
      r_frame_done <= w_tick && (r_row == 2'd3);
      if (w_tick) begin
        r_cnt                         <= '0;
        r_row                         <= r_row + 2'd1;
        r_raw[{r_row, 2'b00} +: 4]    <= ~r_col_s2;
      end else begin
        r_cnt <= r_cnt + 19'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_stored <= '0;
      r_match  <= '0;
      r_deb    <= '0;
    end else begin
      if (r_frame_done) begin
        if (r_raw != r_stored) begin
          r_stored <= r_raw;
          r_match  <= '0;
        end else if (r_match != DEBOUNCE_CNT) begin
          r_match <= w_match_inc;
        end
      end
      if (w_deb_upd) r_deb <= r_stored;
    end
  end

  always_comb begin
    w_key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_stored[i]) w_key_idx = 4'(i);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_OPEN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    if (w_deb_upd) begin
      if (r_stored == '0) begin
        w_state_nxt = ST_OPEN;
      end else if ($onehot(r_stored)) begin
        if (r_state == ST_OPEN) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_LOCKED;
        end
      end else begin
        w_state_nxt = ST_LOCKED;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  logic [7:0] r_rep_cnt;
  logic [7:0] w_rep_inc;
  logic       w_rep_arm;

  assign w_rep_inc  = r_rep_cnt + 8'd1;
  // Armed only while the held key is the one whose code is currently reported.
  assign w_rep_arm  = $onehot(r_deb) && (r_state == ST_LOCKED) && r_deb[r_key_code];
  assign w_rep_fire = r_frame_done && !w_deb_upd && w_rep_arm && (w_rep_inc == REPEAT_FRAMES);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rep_cnt <= '0;
    end else if (w_deb_upd) begin
      r_rep_cnt <= '0;
    end else if (r_frame_done && w_rep_arm) begin
      r_rep_cnt <= (w_rep_inc == REPEAT_FRAMES) ? 8'd0 : w_rep_inc;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      if (w_fire) r_key_code <= w_key_idx;
      r_key_valid <= w_fire || w_rep_fire;
    end
  end

  assign bus.Row_Out   = ~(4'b1000 >> r_row);
  assign bus.Key_Code  = r_key_code;
  assign bus.Key_Valid = r_key_valid;
  assign bus.Key_Down  = |r_deb;

endmodule
